data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-wide, single-port data RAM for the 9-bit RISC CPU.
- Holds program operands and results, e.g. the int-to-float operands at addresses 1–2 and the result at addresses 5–6.
- Writes are synchronous; reads are combinational.
- Benches preload the storage array and inspect it hierarchically, so its name and shape are fixed by this spec.

Parameters:
- W, 8, data word width in bits.
- A, 8, address width in bits; depth = 2**A = 256 words.

Ports:
- clk  input  1  clock; reset is synchronous, active-high, clock clk.
- reset  input  1  synchronous active-high reset.
- DataAddress  input  A  word address for both read and write.
- ReadMem  input  1  read enable.
- WriteMem  input  1  write enable.
- DataIn  input  W  write data.
- DataOut  output  W  read data.

Behaviour:
- Storage: unpacked array named my_memory, 2**A entries of W bits, indexed my_memory[0..2**A-1].
  - Must be a plain variable so benches can read and write it hierarchically, e.g. my_memory[1][7].
- Write:
  - On posedge clk, when WriteMem=1 and reset=0: my_memory[DataAddress] <= DataIn.
  - One write per cycle.
  - No byte enables.
- Read is combinational:
  - ReadMem=1: DataOut = my_memory[DataAddress].
  - ReadMem=0: DataOut = 0.
  - No latency; DataOut follows address and contents changes within the same cycle.
- Read-during-write, same address:
  - Before the clock edge, DataOut shows the old contents.
  - After the edge, it shows DataIn.
  - No bypass.
- ReadMem and WriteMem both high: write occurs at the edge and the read is still driven per the rules above. This is legal, not an error.
- Reset:
  - Does NOT clear my_memory; contents persist across reset so preloaded operands survive.
  - While reset=1, writes are suppressed.
  - DataOut remains purely combinational and is unaffected by reset.
  - Reset mid-operation: a write request in a reset cycle is dropped; all other state is unchanged.
- Addresses always fall in range (full A-bit decode); there is no wrap or aliasing logic.
- Power-up contents are X in simulation. Benches must preload or write before reading.
- No internal state other than my_memory; no FSM.

Decomposition:
- Shared package cpu_pkg holds the width constants: DATA_W=8, DADDR_W=8, and a typedef for the data word (logic [7:0]).
- No sub-modules; single flat module.
- An optional debug task or function for dumping contents may live in the bench, not the RTL.

Test Plan:
- Write then read: write 8'hA5 to addr 8'h05, next cycle ReadMem=1 addr 5 -> DataOut=8'hA5.
- Read disabled: ReadMem=0 at any address after writes -> DataOut=8'h00.
- Reset retention and suppression:
  - Preload my_memory[1]=8'h81 and my_memory[2]=8'h23 hierarchically.
  - Pulse reset 2 cycles with WriteMem=1, DataIn=8'hFF, addr 1.
  - Read addr 1 -> 8'h81; read addr 2 -> 8'h23.
- Read-during-write:
  - addr 6 holds 8'h11; drive WriteMem=1, ReadMem=1, DataIn=8'h22.
  - Before the edge DataOut=8'h11; after the edge DataOut=8'h22.
- Boundaries: write 8'h3C to addr 0 and 8'hC3 to addr 255, then read both -> 8'h3C and 8'hC3; addr 1 and 254 unchanged.
- Back-to-back writes: sequential writes to addrs 0–255 with data = addr ^ 8'h5A, then read all 256 -> each equals addr ^ 8'h5A.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared width constants and word typedef for the 9-bit RISC CPU datapath.
//   DATA_W  : data memory word width (bits)
//   DADDR_W : data memory address width (bits)
//   data_t  : one data memory word
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W  = 8;
   localparam int DADDR_W = 8;

   typedef logic [DATA_W-1:0] data_t;

endpackage : cpu_pkg

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-wide single-port data RAM for the 9-bit RISC CPU. Holds program
// operands and results. Writes are synchronous, reads are combinational.
//
// Ports:
//   clk          in   1  clock
//   reset        in   1  synchronous, active-high; only suppresses writes
//   DataAddress  in   A  word address shared by read and write
//   ReadMem      in   1  read enable (DataOut is zero when low)
//   WriteMem     in   1  write enable (sampled at posedge clk)
//   DataIn       in   W  write data
//   DataOut      out  W  read data
//
// The storage array my_memory is deliberately a plain unpacked variable so
// benches can preload and inspect it hierarchically. It is never cleared by
// reset, so preloaded operands survive a reset pulse.
// -----------------------------------------------------------------------------
module data_memory
   import cpu_pkg::*;
#(
   parameter int W = DATA_W,
   parameter int A = DADDR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [A-1:0] DataAddress,
   input  logic         ReadMem,
   input  logic         WriteMem,
   input  logic [W-1:0] DataIn,
   output logic [W-1:0] DataOut
);

   logic [W-1:0] my_memory [2**A];

   // A write requested during a reset cycle is simply dropped; contents
   // are otherwise untouched by reset.
   always_ff @(posedge clk) begin
      if (!reset && WriteMem) begin
         my_memory[DataAddress] <= DataIn;
      end
   end

   // No write-to-read bypass: during a same-address write the old contents
   // are visible until the edge commits the new word.
   always_comb begin
      DataOut = '0;
      if (ReadMem) begin
         DataOut = my_memory[DataAddress];
      end
   end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory. Inputs change on the falling edge;
// DataOut is sampled 1ns later (before the next rising edge) and, where the
// post-write value matters, 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_memory;

   logic       clk;
   logic       reset;
   logic [7:0] DataAddress;
   logic       ReadMem;
   logic       WriteMem;
   logic [7:0] DataIn;
   logic [7:0] DataOut;

   int checks;
   int errors;

   // Reference model: what the memory should hold, as a plain array.
   logic [7:0] ref_mem [256];

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] din;
      logic [7:0] exp;   // DataOut expected before the edge
   } vec_t;

   vec_t vecs [9];

   data_memory dut (
      .clk         (clk),
      .reset       (reset),
      .DataAddress (DataAddress),
      .ReadMem     (ReadMem),
      .WriteMem    (WriteMem),
      .DataIn      (DataIn),
      .DataOut     (DataOut)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: DataOut=%h expected=%h", name, got, exp);
      end
   endtask

   // Drive inputs on the falling edge, then let them settle.
   task automatic drive(input logic r, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      reset       = r;
      ReadMem     = rd;
      WriteMem    = wr;
      DataAddress = a;
      DataIn      = d;
      #1;
   endtask

   // Model the effect of the upcoming rising edge.
   task automatic model_edge(input logic r, input logic wr,
                             input logic [7:0] a, input logic [7:0] d);
      if (wr && !r) ref_mem[a] = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; ReadMem = 1'b0; WriteMem = 1'b0;
      DataAddress = '0; DataIn = '0;

      // Reset state: read disabled gives zero regardless of contents.
      drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      check("reset_rd_off", DataOut, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Write then read.
      drive(1'b0, 1'b0, 1'b1, 8'h05, 8'hA5);
      model_edge(1'b0, 1'b1, 8'h05, 8'hA5);
      drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
      check("write_then_read", DataOut, 8'hA5);

      // Back-to-back writes over the full address range.
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(i), 8'(i) ^ 8'h5A);
         model_edge(1'b0, 1'b1, 8'(i), 8'(i) ^ 8'h5A);
      end
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'(i), 8'h00);
         check($sformatf("fill_rd[%0d]", i), DataOut, 8'(i) ^ 8'h5A);
      end

      // Table: read-disable, boundary addresses, neighbours untouched.
      vecs[0] = '{rd:1'b0, wr:1'b1, addr:8'h05, din:8'hA5, exp:8'h00};
      vecs[1] = '{rd:1'b1, wr:1'b0, addr:8'h05, din:8'h00, exp:8'hA5};
      vecs[2] = '{rd:1'b0, wr:1'b0, addr:8'h05, din:8'h00, exp:8'h00};
      vecs[3] = '{rd:1'b0, wr:1'b1, addr:8'h00, din:8'h3C, exp:8'h00};
      vecs[4] = '{rd:1'b1, wr:1'b1, addr:8'hFF, din:8'hC3, exp:8'hA5}; // old FF^5A
      vecs[5] = '{rd:1'b1, wr:1'b0, addr:8'h00, din:8'h00, exp:8'h3C};
      vecs[6] = '{rd:1'b1, wr:1'b0, addr:8'hFF, din:8'h00, exp:8'hC3};
      vecs[7] = '{rd:1'b1, wr:1'b0, addr:8'h01, din:8'h00, exp:8'h5B};
      vecs[8] = '{rd:1'b1, wr:1'b0, addr:8'hFE, din:8'h00, exp:8'hA4};
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
         check($sformatf("vec[%0d]", i), DataOut, vecs[i].exp);
         model_edge(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].din);
      end

      // Reset retention and write suppression.
      @(negedge clk);
      dut.my_memory[1] = 8'h81;
      dut.my_memory[2] = 8'h23;
      ref_mem[1] = 8'h81;
      ref_mem[2] = 8'h23;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b1, 8'h01, 8'hFF);
         check($sformatf("rst_rd_live[%0d]", i), DataOut, 8'h81);
         model_edge(1'b1, 1'b1, 8'h01, 8'hFF);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
      check("rst_keep_a1", DataOut, 8'h81);
      drive(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
      check("rst_keep_a2", DataOut, 8'h23);

      // Read-during-write at the same address: no bypass.
      drive(1'b0, 1'b0, 1'b1, 8'h06, 8'h11);
      model_edge(1'b0, 1'b1, 8'h06, 8'h11);
      drive(1'b0, 1'b1, 1'b1, 8'h06, 8'h22);
      check("rdw_before_edge", DataOut, 8'h11);
      model_edge(1'b0, 1'b1, 8'h06, 8'h22);
      @(posedge clk);
      #1;
      check("rdw_after_edge", DataOut, 8'h22);

      // Randomized traffic against the array model.
      for (int i = 0; i < 400; i++) begin
         logic       r, rd, wr;
         logic [7:0] a, d, exp;
         r  = ($urandom_range(0, 9) == 0);
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 255));
         d  = 8'($urandom);
         drive(r, rd, wr, a, d);
         exp = rd ? ref_mem[a] : 8'h00;
         check($sformatf("rand[%0d]", i), DataOut, exp);
         model_edge(r, wr, a, d);
      end

      // Final sweep: every word matches the model.
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'(i), 8'h00);
         check($sformatf("sweep[%0d]", i), DataOut, ref_mem[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_data_memory
